alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 26 ++
 rtl/alu_arbiter_alu.sv | 31 +++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared opcodes, FSM states and opcode helper for alu_arbiter
// Contents:
//   ADD..EQ, IDLE_OP : 3-bit ALU opcode constants (110 and 111 are illegal requests)
//   state_t          : arbiter FSM state encoding
//   op_is_legal()    : 1 for opcodes the ALU implements
package alu_arbiter_pkg;

    localparam logic [2:0] ADD     = 3'b000;
    localparam logic [2:0] NAND    = 3'b001;
    localparam logic [2:0] CMP     = 3'b010;
    localparam logic [2:0] SHL     = 3'b011;
    localparam logic [2:0] SHR     = 3'b100;
    localparam logic [2:0] EQ      = 3'b101;
    localparam logic [2:0] IDLE_OP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= EQ);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational 8-bit ALU used as the arbiter's datapath
// Ports:
//   i_op     in  3  opcode (IDLE_OP and unknown codes give result 0, zero 0)
//   i_a, i_b in  8  operands
//   o_result out 8  result (carry of ADD discarded)
//   o_zero   out 1  1 when EQ and i_a == i_b
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_result,
    output logic       o_zero
);

    always_comb begin
        o_result = 8'h00;
        o_zero   = 1'b0;
        case (i_op)
            ADD:     o_result = i_a + i_b;
            NAND:    o_result = ~(i_a & i_b);
            CMP:     o_result = {7'd0, (i_a < i_b)};
            SHL:     o_result = {i_a[6:0], 1'b0};
            SHR:     o_result = {i_a[7], i_a[7:1]};
            EQ:      o_zero   = (i_a == i_b);
            default: o_result = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin front end sharing one ALU
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   pN_req_valid/ready/op/a/b        request port N (N = 0, 1)
//   rsp_valid/ready                  response handshake
//   rsp_port/result/zero/err         response payload, held while stalled
//   p0_cnt, p1_cnt                   saturating completed-response counters
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       p0_req_valid,
    output logic       p0_req_ready,
    input  logic [2:0] p0_op,
    input  logic [7:0] p0_a,
    input  logic [7:0] p0_b,
    input  logic       p1_req_valid,
    output logic       p1_req_ready,
    input  logic [2:0] p1_op,
    input  logic [7:0] p1_a,
    input  logic [7:0] p1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_port,
    output logic [7:0] rsp_result,
    output logic       rsp_zero,
    output logic       rsp_err,
    output logic [7:0] p0_cnt,
    output logic [7:0] p1_cnt
);

    state_t     r_state;
    logic       r_last_grant;
    logic [2:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_port;
    logic       r_rsp_valid;
    logic       r_rsp_port;
    logic [7:0] r_rsp_result;
    logic       r_rsp_zero;
    logic       r_rsp_err;
    logic [7:0] r_p0_cnt;
    logic [7:0] r_p1_cnt;

    logic       w_idle;
    logic       w_grant;
    logic       w_accept;
    logic [2:0] w_alu_op;
    logic [7:0] w_alu_result;
    logic       w_alu_zero;

    assign w_idle = (r_state == ST_IDLE);

    // A lone requester wins outright; a tie (or no request) favours the
    // port that did not win last, so ready already points there when idle.
    always_comb begin
        w_grant = ~r_last_grant;
        if (p0_req_valid && !p1_req_valid) begin
            w_grant = 1'b0;
        end else if (p1_req_valid && !p0_req_valid) begin
            w_grant = 1'b1;
        end
    end

    assign p0_req_ready = w_idle && !w_grant;
    assign p1_req_ready = w_idle &&  w_grant;
    assign w_accept     = w_idle && (w_grant ? p1_req_valid : p0_req_valid);

    // The ALU sees IDLE_OP outside EXEC and for illegal requests, so every
    // executed legal op is an opcode change at the ALU input.
    assign w_alu_op = (r_state == ST_EXEC && op_is_legal(r_op)) ? r_op : IDLE_OP;

    alu u_alu (
        .i_op     (w_alu_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_op         <= 3'd0;
            r_a          <= 8'h00;
            r_b          <= 8'h00;
            r_port       <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_port   <= 1'b0;
            r_rsp_result <= 8'h00;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_p0_cnt     <= 8'h00;
            r_p1_cnt     <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op         <= w_grant ? p1_op : p0_op;
                        r_a          <= w_grant ? p1_a  : p0_a;
                        r_b          <= w_grant ? p1_b  : p0_b;
                        r_port       <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_result <= w_alu_result;
                    r_rsp_zero   <= w_alu_zero;
                    r_rsp_err    <= !op_is_legal(r_op);
                    r_rsp_port   <= r_port;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                        if (!r_rsp_port) begin
                            if (r_p0_cnt != 8'hFF) r_p0_cnt <= r_p0_cnt + 8'd1;
                        end else begin
                            if (r_p1_cnt != 8'hFF) r_p1_cnt <= r_p1_cnt + 8'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_port   = r_rsp_port;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_err    = r_rsp_err;
    assign p0_cnt     = r_p0_cnt;
    assign p1_cnt     = r_p1_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       p0_req_valid, p1_req_valid;
    logic       p0_req_ready, p1_req_ready;
    logic [2:0] p0_op, p1_op;
    logic [7:0] p0_a, p0_b, p1_a, p1_b;
    logic       rsp_valid, rsp_ready, rsp_port, rsp_zero, rsp_err;
    logic [7:0] rsp_result, p0_cnt, p1_cnt;

    int n_total = 0;
    int n_bad   = 0;
    int ec0     = 0;
    int ec1     = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .p0_req_valid (p0_req_valid),
        .p0_req_ready (p0_req_ready),
        .p0_op        (p0_op),
        .p0_a         (p0_a),
        .p0_b         (p0_b),
        .p1_req_valid (p1_req_valid),
        .p1_req_ready (p1_req_ready),
        .p1_op        (p1_op),
        .p1_a         (p1_a),
        .p1_b         (p1_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_port     (rsp_port),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_err      (rsp_err),
        .p0_cnt       (p0_cnt),
        .p1_cnt       (p1_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic       port;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       z;
        logic       e;
    } vec_t;

    vec_t vecs [13];

    // One full transaction from the negedge region: request, EXEC, RESP, handshake.
    task automatic run_one(input vec_t v);
        int waited;
        if (v.port) begin
            p1_req_valid = 1'b1; p1_op = v.op; p1_a = v.a; p1_b = v.b;
        end else begin
            p0_req_valid = 1'b1; p0_op = v.op; p0_a = v.a; p0_b = v.b;
        end
        rsp_ready = 1'b1;
        #1;
        waited = 0;
        while (!(v.port ? p1_req_ready : p0_req_ready) && waited < 8) begin
            @(negedge clk); #1;
            waited++;
        end
        chk("grant_wait", 32'(waited < 8), 1);
        @(negedge clk);
        p0_req_valid = 1'b0; p1_req_valid = 1'b0; p0_op = 3'd7; p1_op = 3'd7;
        #1;
        chk("exec_quiet", {p0_req_ready, p1_req_ready, rsp_valid}, 0);
        @(negedge clk); #1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_port", rsp_port, v.port);
        chk("rsp_result", rsp_result, v.r);
        chk("rsp_zero", rsp_zero, v.z);
        chk("rsp_err", rsp_err, v.e);
        chk("resp_no_ready", {p0_req_ready, p1_req_ready}, 0);
        @(negedge clk); #1;
        if (v.port) ec1++; else ec0++;
        chk("rsp_drop", rsp_valid, 0);
        chk("p0_cnt", p0_cnt, ec0);
        chk("p1_cnt", p1_cnt, ec1);
    endtask

    initial begin
        int n, hs, cyc, w;
        vecs[0]  = '{1'b0, 3'b000, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 3'b110, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 3'b100, 8'h80, 8'h00, 8'hC0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'b011, 8'h41, 8'h00, 8'h82, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 3'b011, 8'h41, 8'h00, 8'h82, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 3'b001, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 3'b010, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 3'b010, 8'h05, 8'h03, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 3'b000, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 3'b101, 8'h5A, 8'h5B, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 3'b111, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 3'b101, 8'h77, 8'h77, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 3'b100, 8'h7E, 8'h00, 8'h3F, 1'b0, 1'b0};

        rst_n = 1'b0; rsp_ready = 1'b0;
        p0_req_valid = 1'b0; p0_op = 3'd0; p0_a = 8'h00; p0_b = 8'h00;
        p1_req_valid = 1'b0; p1_op = 3'd0; p1_a = 8'h00; p1_b = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rsp", {rsp_valid, rsp_port, rsp_result, rsp_zero, rsp_err}, 0);
        chk("rst_cnt", {p0_cnt, p1_cnt}, 0);
        chk("rst_pref", {p0_req_ready, p1_req_ready}, 2'b10);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: single add, illegal, shr, back-to-back shl, misc ops.
        for (int i = 0; i < 13; i++) run_one(vecs[i]);

        // Back-pressure on an EQ from port 1.
        p1_req_valid = 1'b1; p1_op = 3'b101; p1_a = 8'h5A; p1_b = 8'h5A;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant", p1_req_ready, 1);
        @(negedge clk);
        p1_req_valid = 1'b0;
        @(negedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {rsp_valid, rsp_port, rsp_zero, rsp_err, rsp_result}, {4'b1110, 8'h00});
            chk("bp_ready", {p0_req_ready, p1_req_ready}, 0);
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_ready", {p0_req_ready, p1_req_ready, rsp_valid}, 3'b001);
        @(negedge clk); #1;
        ec1++;
        chk("bp_done", rsp_valid, 0);
        chk("bp_cnt", p1_cnt, ec1);

        // Contention from reset: grants alternate 0,1,0,1.
        rst_n = 1'b0;
        p0_req_valid = 1'b1; p0_op = 3'b000; p0_a = 8'h01; p0_b = 8'h01;
        p1_req_valid = 1'b1; p1_op = 3'b000; p1_a = 8'h10; p1_b = 8'h10;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid && rsp_ready) begin
                chk("cont_port", rsp_port, n % 2);
                chk("cont_result", rsp_result, (n % 2) ? 8'h20 : 8'h02);
                n++;
            end
            @(negedge clk); #1;
        end
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        chk("cont_count", n, 4);
        chk("cont_cnts", {p0_cnt, p1_cnt}, {8'd2, 8'd2});

        // Saturation of p0_cnt.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        p0_req_valid = 1'b1; p0_op = 3'b000;
        rsp_ready = 1'b1;
        #1;
        hs = 0; cyc = 0;
        while (hs < 256 && cyc < 3000) begin
            if (rsp_valid && rsp_ready) begin
                hs++;
                if (hs == 255) chk("sat_fe", p0_cnt, 8'hFE);
                if (hs == 256) chk("sat_ff", p0_cnt, 8'hFF);
            end
            @(negedge clk); #1;
            cyc++;
        end
        p0_req_valid = 1'b0;
        chk("sat_hs", hs, 256);
        chk("sat_nowrap", p0_cnt, 8'hFF);

        // Reset during RESP abandons the transaction.
        p1_req_valid = 1'b1; p1_op = 3'b000; p1_a = 8'h01; p1_b = 8'h02;
        rsp_ready = 1'b0;
        #1;
        w = 0;
        while (!rsp_valid && w < 10) begin
            @(negedge clk); #1;
            w++;
        end
        chk("rr_wait", rsp_valid, 1);
        p1_req_valid = 1'b0; rst_n = 1'b0; rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("rr_valid", rsp_valid, 0);
        chk("rr_cnts", {p0_cnt, p1_cnt}, 0);
        rst_n = 1'b1;
        p0_req_valid = 1'b1; p0_op = 3'b011; p0_a = 8'h03; p0_b = 8'h00;
        p1_req_valid = 1'b1;
        #1;
        chk("rr_grant", {p0_req_ready, p1_req_ready}, 2'b10);
        @(negedge clk);
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        @(negedge clk); #1;
        chk("rr_rsp", {rsp_valid, rsp_port, rsp_result}, {2'b10, 8'h06});
        @(negedge clk); #1;
        chk("rr_cnt", p0_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
